// File: rtl/mandelbrot_pkg.sv
// Shared types and helpers for the Mandelbrot result collector.
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mandelbrot_result_arb_sync_fifo.sv
// Synchronous FIFO buffering merged results ahead of the output stream.
// clr flushes the contents and wins over a same-cycle write or read.
module sync_fifo #(
  parameter int DW = 27,
  parameter int FD = 8
) (
  input  logic          clk,
  input  logic          clk_en,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] in,
  input  logic          rd_en,
  output logic [DW-1:0] out,
  output logic          empty,
  output logic          full
);

  localparam int PTRW = (FD > 1) ? $clog2(FD) : 1;
  localparam int LVLW = $clog2(FD + 1);

  logic [DW-1:0]   mem_q [FD];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0] level_q, level_d;
  logic            push;
  logic            pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVLW'(FD));
  assign out   = mem_q[rd_ptr_q];

  // Pointer and level update; FD is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    push     = 1'b0;
    pop      = 1'b0;
    if (clk_en) begin
      if (clr) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        level_d  = '0;
      end else begin
        push = wr_en & ~full;
        pop  = rd_en & ~empty;
        if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
        if (push && !pop)      level_d = level_q + LVLW'(1);
        else if (pop && !push) level_d = level_q - LVLW'(1);
      end
    end
  end

  // Storage array; no reset needed since contents are only read when non-empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in;
  end

  // Pointer and level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/mandelbrot_result_arb.sv
// Round-robin collector merging NCH engine result streams into one buffered
// {adr,niter} stream, counting results per frame and flagging frame completion.
// Optional per-channel accept counters: define MAN_ARB_STATS_EN.
//
//  state | meaning
//  IDLE  | after reset, waiting for the first init edge
//  RUN   | accepting results until NPIXELS have been taken
//  DRAIN | all results accepted, emptying the buffer downstream
//  DONE  | NPIXELS results delivered, waiting for the next init edge
module mandelbrot_result_arb
  import mandelbrot_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int AW      = 19,
  parameter int DW      = 8,
  parameter int NPIXELS = 480000,
  parameter int FD      = 8,
  localparam int CW     = cw(NPIXELS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic            init,
  output logic            busy,
  output logic            done,
  input  logic [NCH-1:0]  in_vld,
  output logic [NCH-1:0]  in_rdy,
  input  logic [NCH*DW-1:0] in_dat,
  input  logic [NCH*AW-1:0] in_adr,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [DW-1:0]   out_dat,
  output logic [AW-1:0]   out_adr
`ifdef MAN_ARB_STATS_EN
  ,
  output logic [NCH*CW-1:0] stat_cnt
`endif
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  arb_state_t      state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [CW-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic            init_q, init_d;

  logic            start;
  logic            grant_vld;
  logic [PW-1:0]   grant_idx;
  logic [PW:0]     scan_sum;
  logic [PW-1:0]   scan_sel;
  logic            accept;
  logic            pop;
  logic [AW+DW-1:0] push_data;
  logic [AW+DW-1:0] fifo_out;
  logic            fifo_empty;
  logic            fifo_full;

  assign start = clk_en & init & ~init_q;

  // Round-robin search: first valid channel at or after the pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_sel  = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_sum = {1'b0, rr_q} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NCH)) scan_sum = scan_sum - (PW+1)'(NCH);
      scan_sel = PW'(scan_sum);
      if (!grant_vld && in_vld[scan_sel]) begin
        grant_vld = 1'b1;
        grant_idx = scan_sel;
      end
    end
  end

  // Handshakes. A start cycle flushes the buffer, so nothing is accepted then
  // to avoid dropping a result the engine believes was taken.
  always_comb begin
    accept = clk_en & (state_q == RUN) & ~fifo_full & ~start & grant_vld
           & (acc_cnt_q < CW'(NPIXELS));
    in_rdy = '0;
    if (accept) in_rdy[grant_idx] = 1'b1;
    push_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_idx == PW'(i)) push_data = {in_adr[i*AW +: AW], in_dat[i*DW +: DW]};
    end
  end

  assign out_vld = clk_en & ~fifo_empty;
  assign pop     = out_vld & out_rdy;
  assign out_dat = fifo_empty ? '0 : fifo_out[DW-1:0];
  assign out_adr = fifo_empty ? '0 : fifo_out[AW+DW-1:DW];
  assign busy    = (state_q == RUN) || (state_q == DRAIN);
  assign done    = (state_q == DONE);

  sync_fifo #(
    .DW (AW + DW),
    .FD (FD)
  ) u_fifo (
    .clk    (clk),
    .clk_en (clk_en),
    .rst    (rst),
    .clr    (start),
    .wr_en  (accept),
    .in     (push_data),
    .rd_en  (pop),
    .out    (fifo_out),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Next-state logic: frame FSM, pointer and frame counters. DONE is entered
  // from the post-pop count so done rises the cycle after the last pop.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    acc_cnt_d = acc_cnt_q;
    out_cnt_d = out_cnt_q;
    init_d    = init_q;
    if (clk_en) begin
      init_d = init;
      if (start) begin
        state_d   = RUN;
        rr_d      = '0;
        acc_cnt_d = '0;
        out_cnt_d = '0;
      end else begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + CW'(1);
          rr_d      = (grant_idx == PW'(NCH - 1)) ? '0 : grant_idx + PW'(1);
        end
        if (pop) out_cnt_d = out_cnt_q + CW'(1);
        case (state_q)
          RUN: begin
            if (out_cnt_d == CW'(NPIXELS))      state_d = DONE;
            else if (acc_cnt_d == CW'(NPIXELS)) state_d = DRAIN;
          end
          DRAIN: begin
            if (out_cnt_d == CW'(NPIXELS)) state_d = DONE;
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  // State, pointer and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      acc_cnt_q <= '0;
      out_cnt_q <= '0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      acc_cnt_q <= acc_cnt_d;
      out_cnt_q <= out_cnt_d;
      init_q    <= init_d;
    end
  end

`ifdef MAN_ARB_STATS_EN
  logic [CW-1:0] stat_q [NCH];
  logic [CW-1:0] stat_d [NCH];

  // Per-channel accept counters, saturating at NPIXELS.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      stat_d[i] = stat_q[i];
      if (clk_en) begin
        if (start) begin
          stat_d[i] = '0;
        end else if (accept && grant_idx == PW'(i) && stat_q[i] < CW'(NPIXELS)) begin
          stat_d[i] = stat_q[i] + CW'(1);
        end
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) stat_q[i] <= '0;
      else     stat_q[i] <= stat_d[i];
    end
  end

  // Flatten counters onto the output bus.
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NCH; i++) stat_cnt[i*CW +: CW] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_mandelbrot_result_arb.sv
// Self-checking bench for mandelbrot_result_arb (NCH=4, NPIXELS=16, FD=8).
module tb_mandelbrot_result_arb;

  localparam int NCH = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int NP  = 16;
  localparam int FD  = 8;
  localparam int CW  = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            clk_en;
  logic            init;
  logic            busy;
  logic            done;
  logic [NCH-1:0]  in_vld;
  logic [NCH-1:0]  in_rdy;
  logic [NCH*DW-1:0] in_dat;
  logic [NCH*AW-1:0] in_adr;
  logic            out_vld;
  logic            out_rdy;
  logic [DW-1:0]   out_dat;
  logic [AW-1:0]   out_adr;
`ifdef MAN_ARB_STATS_EN
  logic [NCH*CW-1:0] stat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mandelbrot_result_arb #(
    .NCH(NCH), .AW(AW), .DW(DW), .NPIXELS(NP), .FD(FD)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .init(init),
    .busy(busy), .done(done),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_adr(in_adr),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .out_adr(out_adr)
`ifdef MAN_ARB_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  typedef struct {
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] rdy;
    logic       ovld;
    logic [7:0] dat;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fixed_data();
    for (int i = 0; i < NCH; i++) begin
      in_dat[i*DW +: DW] = 8'(8'hA0 + i);
      in_adr[i*AW +: AW] = 8'(8'h50 + i);
    end
  endtask

  task automatic start_frame();
    in_vld = '0;
    init   = 1'b1;
    @(posedge clk); #1;
    init   = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, npop, nacc;
    logic early_done, first;
    logic [3:0] last_rdy;
    int rr_m, acc_m, popped, g;
    int n_ch [NCH];
    logic [3:0] exp_rdy;
    logic exp_ovld;
    logic [15:0] q [$];

    tbl[0]  = '{4'hF, 1'b1, 4'h1, 1'b0, 8'h00};
    tbl[1]  = '{4'hF, 1'b1, 4'h2, 1'b1, 8'hA0};
    tbl[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 8'hA1};
    tbl[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 8'hA2};
    tbl[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 8'hA3};
    tbl[5]  = '{4'hF, 1'b1, 4'h2, 1'b1, 8'hA0};
    tbl[6]  = '{4'hF, 1'b1, 4'h4, 1'b1, 8'hA1};
    tbl[7]  = '{4'hF, 1'b1, 4'h8, 1'b1, 8'hA2};
    tbl[8]  = '{4'h4, 1'b1, 4'h4, 1'b1, 8'hA3};
    tbl[9]  = '{4'hA, 1'b1, 4'h8, 1'b1, 8'hA2};
    tbl[10] = '{4'hA, 1'b1, 4'h2, 1'b1, 8'hA3};
    tbl[11] = '{4'h0, 1'b1, 4'h0, 1'b1, 8'hA1};
    tbl[12] = '{4'h0, 1'b1, 4'h0, 1'b0, 8'h00};

    rst = 1'b1; clk_en = 1'b1; init = 1'b0; in_vld = '0; out_rdy = 1'b0;
    fixed_data();
    repeat (3) @(posedge clk);
    #1; in_vld = 4'hF; out_rdy = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_dat", out_dat, 0);
    chk("rst_out_adr", out_adr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_rdy", in_rdy, 0);
    @(posedge clk); #1;

    // Round-robin rotation and skip-ahead from a mid pointer.
    start_frame();
    for (int r = 0; r < 13; r++) begin
      in_vld = tbl[r].vld; out_rdy = tbl[r].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_rdy", r), in_rdy, tbl[r].rdy);
      chk($sformatf("tbl%0d_out_vld", r), out_vld, tbl[r].ovld);
      if (tbl[r].ovld) begin
        chk($sformatf("tbl%0d_out_dat", r), out_dat, tbl[r].dat);
        chk($sformatf("tbl%0d_out_adr", r), out_adr, 8'(tbl[r].dat - 8'h50));
      end
      @(posedge clk); #1;
    end

    // Fill with downstream stalled: exactly FD accepts.
    start_frame();
    n = 0; last_rdy = '0;
    in_vld = 4'hF; out_rdy = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (|(in_vld & in_rdy)) n++;
      last_rdy = in_rdy;
      @(posedge clk); #1;
    end
    chk("fill_accepts", n, FD);
    chk("fill_in_rdy", last_rdy, 0);
    out_rdy = 1'b1;
    @(negedge clk);
    chk("full_pop_no_push", in_rdy, 0);
    chk("drain0_dat", out_dat, 8'hA0);
    @(posedge clk); #1;
    in_vld = '0;
    for (int k = 1; k < FD; k++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_vld", k), out_vld, 1);
      chk($sformatf("drain%0d_dat", k), out_dat, 8'(8'hA0 + (k % 4)));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain_empty", out_vld, 0);
    @(posedge clk); #1;

    // Frame end: remaining 8 accepts, done one cycle after the 16th pop.
    in_vld = 4'hF; out_rdy = 1'b1;
    nacc = 0; npop = 0; early_done = 1'b0;
    for (int c = 0; c < 40 && npop < NP - FD; c++) begin
      @(negedge clk);
      if (|(in_vld & in_rdy)) nacc++;
      if (out_vld && out_rdy) npop++;
      if (done) early_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("end_pops", npop, NP - FD);
    chk("end_early_done", early_done, 0);
    @(negedge clk);
    chk("end_accepts", nacc, NP - FD);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_in_rdy", in_rdy, 0);
    @(posedge clk); #1;

    // Restart from DONE, then again mid-RUN with 5 results buffered.
    start_frame();
    in_vld = 4'hF; out_rdy = 1'b0; n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (|(in_vld & in_rdy)) n++;
      @(posedge clk); #1;
    end
    chk("restart_buffered", n, 5);
    in_vld = '0; init = 1'b1;
    @(negedge clk);
    chk("restart_pre_vld", out_vld, 1);
    @(posedge clk); #1;
    init = 1'b0;
    @(negedge clk);
    chk("restart_out_vld", out_vld, 0);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);
`ifdef MAN_ARB_STATS_EN
    chk("restart_stats", stat_cnt, 0);
`endif
    @(posedge clk); #1;
    in_vld = 4'hF; out_rdy = 1'b1;
    nacc = 0; npop = 0; first = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (|(in_vld & in_rdy)) nacc++;
      if (out_vld && out_rdy) begin
        if (first) chk("restart_first_dat", out_dat, 8'hA0);
        first = 1'b0;
        npop++;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    chk("restart_accepts", nacc, NP);
    chk("restart_pops", npop, NP);
    chk("restart_frame_done", done, 1);
    @(posedge clk); #1;

    // Random traffic with clk_en toggling, against a reference model.
    start_frame();
    rr_m = 0; acc_m = 0; popped = 0;
    for (int i = 0; i < NCH; i++) n_ch[i] = 0;
    for (int c = 0; c < 800 && popped < NP; c++) begin
      clk_en  = 1'($urandom_range(0, 1));
      in_vld  = 4'($urandom_range(0, 15));
      out_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NCH; i++) begin
        in_dat[i*DW +: DW] = 8'(i * 64 + n_ch[i]);
        in_adr[i*AW +: AW] = 8'(8'hC0 + i * 16 + n_ch[i]);
      end
      @(negedge clk);
      g = -1;
      for (int k = 0; k < NCH; k++) begin
        if (g < 0 && in_vld[(rr_m + k) % NCH]) g = (rr_m + k) % NCH;
      end
      exp_rdy = '0;
      if (clk_en && acc_m < NP && q.size() < FD && g >= 0) exp_rdy[g] = 1'b1;
      exp_ovld = clk_en && (q.size() > 0);
      chk($sformatf("rnd%0d_in_rdy", c), in_rdy, exp_rdy);
      chk($sformatf("rnd%0d_out_vld", c), out_vld, exp_ovld);
      if (exp_ovld) chk($sformatf("rnd%0d_out_data", c), {out_adr, out_dat}, q[0]);
      if (exp_ovld && out_rdy) begin
        void'(q.pop_front());
        popped++;
      end
      if (exp_rdy != 0) begin
        q.push_back({in_adr[g*AW +: AW], in_dat[g*DW +: DW]});
        rr_m = (g + 1) % NCH;
        acc_m++;
        n_ch[g]++;
      end
      @(posedge clk); #1;
    end
    chk("rnd_pops", popped, NP);
    clk_en = 1'b1; in_vld = '0;
    @(negedge clk);
    chk("rnd_done", done, 1);
`ifdef MAN_ARB_STATS_EN
    n = 0;
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("rnd_stat%0d", i), stat_cnt[i*CW +: CW], n_ch[i]);
      n += int'(stat_cnt[i*CW +: CW]);
    end
    chk("rnd_stat_sum", n, NP);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
